key_debounce: RTL and testbench

Debounce and event-qualification stage between the keypad scanner and the key sequence generator, running in the 20 Hz scan domain. Takes the scanner's raw key code and key-pressed level, requires a key to be stable for a programmable number of samples, and emits exactly one single-cycle key event per physical press. Also provides optional hold-to-repeat, a held-key level and a release pulse, with no rollover: a second key is ignored until all keys are released.

---
 rtl/key_debounce.sv | 128 ++++++++++++
 tb/tb_key_debounce.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key debounce with single-event qualification, hold-to-repeat and no rollover
module key_debounce #(
    parameter int STABLE_COUNT = 3,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 4
) (
    input  logic       clk_20Hz,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    input  logic       key_pressed,
    output logic [3:0] key_out,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release
);

    localparam logic [3:0] CNT_LAST   = 4'(STABLE_COUNT - 1);
    localparam bit         REPEAT_EN  = (REPEAT_DELAY != 0);
    localparam logic [7:0] RPT_LAST   = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RPT_RELOAD = 8'(REPEAT_DELAY - REPEAT_RATE);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t     state, state_n;
    logic [3:0] cand, cand_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] rpt, rpt_n;
    logic [3:0] key_out_n;
    logic       key_valid_n, key_held_n, key_release_n;

    always_ff @(posedge clk_20Hz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand        <= 4'h0;
            cnt         <= 4'h0;
            rpt         <= 8'h00;
            key_out     <= 4'h0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            cnt         <= cnt_n;
            rpt         <= rpt_n;
            key_out     <= key_out_n;
            key_valid   <= key_valid_n;
            key_held    <= key_held_n;
            key_release <= key_release_n;
        end
    end

    always_comb begin
        state_n       = state;
        cand_n        = cand;
        cnt_n         = cnt;
        rpt_n         = rpt;
        key_out_n     = key_out;
        key_valid_n   = 1'b0;
        key_held_n    = key_held;
        key_release_n = 1'b0;

        case (state)
            IDLE: begin
                if (key_pressed) begin
                    cand_n  = key_in;
                    cnt_n   = 4'd1;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_pressed) begin
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else if (key_in != cand) begin
                    cand_n = key_in;
                    cnt_n  = 4'd1;
                end else if (cnt == CNT_LAST) begin
                    key_out_n   = cand;
                    key_valid_n = 1'b1;
                    key_held_n  = 1'b1;
                    rpt_n       = 8'd0;
                    cnt_n       = 4'd0;
                    state_n     = PRESSED;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            PRESSED: begin
                // A different code while held is treated as the start of a release.
                if (!key_pressed || key_in != key_out) begin
                    cnt_n   = 4'd1;
                    state_n = RELEASE;
                end else if (REPEAT_EN) begin
                    if (rpt == RPT_LAST) begin
                        key_valid_n = 1'b1;
                        rpt_n       = RPT_RELOAD;
                    end else if (rpt != 8'hFF) begin
                        rpt_n = rpt + 8'd1;
                    end
                end
            end
            RELEASE: begin
                if (!key_pressed) begin
                    if (cnt == CNT_LAST) begin
                        key_held_n    = 1'b0;
                        key_release_n = 1'b1;
                        cnt_n         = 4'd0;
                        state_n       = IDLE;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end else if (key_in == key_out) begin
                    state_n = PRESSED;
                end else begin
                    cnt_n = 4'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - table-driven and directed bench for key_debounce
module tb_key_debounce;

    logic       clk_20Hz = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic       key_pressed;
    logic [3:0] key_out, key_out_r;
    logic       key_valid, key_held, key_release;
    logic       key_valid_r, key_held_r, key_release_r;

    int total = 0;
    int passed = 0;

    always #5 clk_20Hz = ~clk_20Hz;

    key_debounce dut (
        .clk_20Hz    (clk_20Hz),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_pressed (key_pressed),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .key_release (key_release)
    );

    key_debounce #(.STABLE_COUNT(3), .REPEAT_DELAY(20), .REPEAT_RATE(4)) dut_rpt (
        .clk_20Hz    (clk_20Hz),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_pressed (key_pressed),
        .key_out     (key_out_r),
        .key_valid   (key_valid_r),
        .key_held    (key_held_r),
        .key_release (key_release_r)
    );

    typedef struct {
        logic       kp;
        logic [3:0] kin;
        logic [3:0] eout;
        logic       ev;
        logic       eh;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic kp, input logic [3:0] kin, input logic [3:0] eout,
                       input logic ev, input logic eh, input logic er);
        vec_t v;
        v.kp = kp; v.kin = kin; v.eout = eout; v.ev = ev; v.eh = eh; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got {out,valid,held,rel}=%h required %h", name, act, exp);
    endtask

    task automatic step(input logic kp, input logic [3:0] kin);
        key_pressed = kp;
        key_in      = kin;
        @(posedge clk_20Hz);
        #1;
    endtask

    function automatic logic [6:0] pk(input logic [3:0] o, input logic v, input logic h, input logic r);
        return {o, v, h, r};
    endfunction

    int cnt_default;

    initial begin
        rst_n = 1'b0;
        key_pressed = 1'b0;
        key_in = 4'h0;
        #2;
        chk("reset_state", {key_out, key_valid, key_held, key_release}, 7'h00);
        chk("reset_state_rpt", {key_out_r, key_valid_r, key_held_r, key_release_r}, 7'h00);
        @(posedge clk_20Hz);
        #1;
        rst_n = 1'b1;

        // clean press of 5
        add(1, 4'h5, 4'h0, 0, 0, 0);
        add(1, 4'h5, 4'h0, 0, 0, 0);
        add(1, 4'h5, 4'h5, 1, 1, 0);
        for (int i = 0; i < 7; i++) add(1, 4'h5, 4'h5, 0, 1, 0);
        add(0, 4'h5, 4'h5, 0, 1, 0);
        add(0, 4'h5, 4'h5, 0, 1, 0);
        add(0, 4'h5, 4'h5, 0, 0, 1);
        add(0, 4'h5, 4'h5, 0, 0, 0);
        add(0, 4'h5, 4'h5, 0, 0, 0);
        // bounce on A: 1,0,1,1,0,1,1,1
        add(1, 4'hA, 4'h5, 0, 0, 0);
        add(0, 4'hA, 4'h5, 0, 0, 0);
        add(1, 4'hA, 4'h5, 0, 0, 0);
        add(1, 4'hA, 4'h5, 0, 0, 0);
        add(0, 4'hA, 4'h5, 0, 0, 0);
        add(1, 4'hA, 4'h5, 0, 0, 0);
        add(1, 4'hA, 4'h5, 0, 0, 0);
        add(1, 4'hA, 4'hA, 1, 1, 0);
        add(1, 4'hA, 4'hA, 0, 1, 0);
        add(0, 4'hA, 4'hA, 0, 1, 0);
        add(0, 4'hA, 4'hA, 0, 1, 0);
        add(0, 4'hA, 4'hA, 0, 0, 1);
        add(0, 4'h0, 4'hA, 0, 0, 0);
        // code change during debounce: 3,7,7,7
        add(1, 4'h3, 4'hA, 0, 0, 0);
        add(1, 4'h7, 4'hA, 0, 0, 0);
        add(1, 4'h7, 4'hA, 0, 0, 0);
        add(1, 4'h7, 4'h7, 1, 1, 0);
        add(1, 4'h7, 4'h7, 0, 1, 0);
        add(0, 4'h7, 4'h7, 0, 1, 0);
        add(0, 4'h7, 4'h7, 0, 1, 0);
        add(0, 4'h7, 4'h7, 0, 0, 1);
        add(0, 4'h0, 4'h7, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].kp, vecs[i].kin);
            chk($sformatf("vec%0d", i), {key_out, key_valid, key_held, key_release},
                pk(vecs[i].eout, vecs[i].ev, vecs[i].eh, vecs[i].er));
        end

        // rollover: 9 ignored while 2 is held
        step(1, 4'h2);
        step(1, 4'h2);
        step(1, 4'h2);
        chk("roll_accept2", {key_out, key_valid, key_held, key_release}, pk(4'h2, 1, 1, 0));
        for (int i = 0; i < 10; i++) begin
            step(1, 4'h9);
            chk($sformatf("roll_hold9_%0d", i), {key_out, key_valid, key_held, key_release}, pk(4'h2, 0, 1, 0));
        end
        step(0, 4'h0);
        step(0, 4'h0);
        chk("roll_rel_wait", {key_out, key_valid, key_held, key_release}, pk(4'h2, 0, 1, 0));
        step(0, 4'h0);
        chk("roll_release", {key_out, key_valid, key_held, key_release}, pk(4'h2, 0, 0, 1));
        step(1, 4'h9);
        step(1, 4'h9);
        chk("roll_deb9", {key_out, key_valid, key_held, key_release}, pk(4'h2, 0, 0, 0));
        step(1, 4'h9);
        chk("roll_accept9", {key_out, key_valid, key_held, key_release}, pk(4'h9, 1, 1, 0));
        step(0, 4'h0);
        step(0, 4'h0);
        step(0, 4'h0);
        chk("roll_release9", {key_out, key_valid, key_held, key_release}, pk(4'h9, 0, 0, 1));

        // auto-repeat on the second instance
        rst_n = 1'b0;
        @(posedge clk_20Hz);
        #1;
        rst_n = 1'b1;
        cnt_default = 0;
        for (int i = 1; i <= 40; i++) begin
            logic ev;
            step(1, 4'hC);
            ev = (i == 3 || i == 23 || i == 27 || i == 31 || i == 35 || i == 39);
            if (key_valid) cnt_default++;
            chk($sformatf("rpt_cyc%0d", i), {key_out_r, key_valid_r, key_held_r, key_release_r},
                pk((i >= 3) ? 4'hC : 4'h0, ev, (i >= 3), 1'b0));
        end
        chk("norpt_pulses", 7'(cnt_default), 7'd1);
        step(0, 4'h0);
        step(0, 4'h0);
        step(0, 4'h0);
        chk("rpt_release", {key_out_r, key_valid_r, key_held_r, key_release_r}, pk(4'hC, 0, 0, 1));

        // reset mid-debounce and mid-press
        step(1, 4'h4);
        rst_n = 1'b0;
        #1;
        chk("rst_deb_imm", {key_out, key_valid, key_held, key_release}, 7'h00);
        chk("rst_deb_imm_rpt", {key_out_r, key_valid_r, key_held_r, key_release_r}, 7'h00);
        @(posedge clk_20Hz);
        #1;
        rst_n = 1'b1;
        step(1, 4'h4);
        chk("post_rst1_a", {key_out, key_valid, key_held, key_release}, 7'h00);
        step(1, 4'h4);
        chk("post_rst1_b", {key_out, key_valid, key_held, key_release}, 7'h00);
        step(1, 4'h4);
        chk("post_rst1_acc", {key_out, key_valid, key_held, key_release}, pk(4'h4, 1, 1, 0));
        step(1, 4'h4);
        chk("post_rst1_held", {key_out, key_valid, key_held, key_release}, pk(4'h4, 0, 1, 0));
        rst_n = 1'b0;
        #1;
        chk("rst_press_imm", {key_out, key_valid, key_held, key_release}, 7'h00);
        @(posedge clk_20Hz);
        #1;
        rst_n = 1'b1;
        step(1, 4'h4);
        step(1, 4'h4);
        chk("post_rst2_wait", {key_out, key_valid, key_held, key_release}, 7'h00);
        step(1, 4'h4);
        chk("post_rst2_acc", {key_out, key_valid, key_held, key_release}, pk(4'h4, 1, 1, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
